// File: rtl/cpu_ifetch.sv
// Instruction-fetch stage: owns the PC, drives the 1-cycle IMEM read port and
// feeds decode from a 2-entry buffer; stops fetching on HALT and flags halted.
//
// state   | meaning
// --------+----------------------------------------------------------------
// FETCH   | issuing reads whenever the buffer has room for the response
// STOP    | HALT word enqueued; no new reads, waiting for decode to take it
// HALTED  | HALT consumed; buffer empty, redirects ignored until reset
module cpu_ifetch #(
   parameter int                ADDR_W   = 8,
   parameter logic [ADDR_W-1:0] RESET_PC = '0,
   parameter logic [3:0]        HALT_OPC = 4'hF
) (
   input  logic              clk,
   input  logic              reset,
   output logic              imem_en,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic [15:0]       imem_rdata,
   input  logic              redirect_valid,
   input  logic [ADDR_W-1:0] redirect_pc,
   output logic              id_valid,
   input  logic              id_ready,
   output logic [15:0]       id_instr,
   output logic [ADDR_W-1:0] id_pc,
   output logic              halted
);

   typedef enum logic [1:0] {
      FETCH  = 2'd0,
      STOP   = 2'd1,
      HALTED = 2'd2
   } state_t;

   state_t            state, state_next;
   logic [ADDR_W-1:0] pc;
   logic              inflight;
   logic [ADDR_W-1:0] inflight_pc;

   logic [1:0]        count;
   logic [15:0]       e0_instr, e1_instr;
   logic [ADDR_W-1:0] e0_pc, e1_pc;

   logic              redirect_eff;
   logic              pop, push, issue, flush;
   logic              halt_push, halt_pop;
   logic [2:0]        occ;

   assign redirect_eff = redirect_valid && (state != HALTED);
   assign id_valid     = (count != 2'd0) && (state != HALTED);
   assign id_instr     = e0_instr;
   assign id_pc        = e0_pc;
   assign pop          = id_valid && id_ready;

   // A response landing during a redirect belongs to the old path and is dropped.
   assign push      = inflight && !redirect_eff && (state != HALTED);
   assign halt_push = push && (imem_rdata[15:12] == HALT_OPC) && (state == FETCH);
   assign halt_pop  = pop && (e0_instr[15:12] == HALT_OPC) && (state == STOP);

   // Occupancy after this edge; a new read needs one free slot one cycle later.
   assign occ   = {1'b0, count} + {2'b00, inflight} - {2'b00, pop};
   assign issue = !reset && (state == FETCH) && !redirect_eff && (occ < 3'd2);

   assign imem_en   = issue;
   assign imem_addr = pc;
   assign halted    = (state == HALTED);

   assign flush = redirect_eff || halt_pop || (state == HALTED);

   always_comb begin
      state_next = state;
      case (state)
         FETCH: begin
            if (redirect_eff)   state_next = FETCH;
            else if (halt_push) state_next = STOP;
         end
         STOP: begin
            if (redirect_eff)  state_next = FETCH;
            else if (halt_pop) state_next = HALTED;
         end
         HALTED:  state_next = HALTED;
         default: state_next = FETCH;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= FETCH;
         pc          <= RESET_PC;
         inflight    <= 1'b0;
         inflight_pc <= '0;
      end else begin
         state       <= state_next;
         inflight    <= issue;
         inflight_pc <= pc;
         if (redirect_eff)
            pc <= redirect_pc;
         else if (issue)
            pc <= pc + 1'b1;
      end
   end

   // Entry 0 is always the head; a pop shifts entry 1 down.
   always_ff @(posedge clk) begin
      if (reset || flush) begin
         count <= 2'd0;
      end else begin
         case ({push, pop})
            2'b01: begin
               e0_instr <= e1_instr;
               e0_pc    <= e1_pc;
               count    <= count - 2'd1;
            end
            2'b10: begin
               if (count == 2'd0) begin
                  e0_instr <= imem_rdata;
                  e0_pc    <= inflight_pc;
               end else begin
                  e1_instr <= imem_rdata;
                  e1_pc    <= inflight_pc;
               end
               count <= count + 2'd1;
            end
            2'b11: begin
               if (count == 2'd1) begin
                  e0_instr <= imem_rdata;
                  e0_pc    <= inflight_pc;
               end else begin
                  e0_instr <= e1_instr;
                  e0_pc    <= e1_pc;
                  e1_instr <= imem_rdata;
                  e1_pc    <= inflight_pc;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_cpu_ifetch.sv
// Directed bench for cpu_ifetch: a cycle table for the straight-line program
// plus hand sequences for stalls, redirects, wrap and reset in STOP.
module tb_cpu_ifetch;

   logic        clk = 1'b0;
   logic        reset;
   always #5 clk = ~clk;

   logic        imem_en1, imem_en2;
   logic [7:0]  imem_addr1, imem_addr2;
   logic [15:0] imem_rdata1, imem_rdata2;
   logic        redirect_valid1, redirect_valid2;
   logic [7:0]  redirect_pc1, redirect_pc2;
   logic        id_valid1, id_valid2;
   logic        id_ready1, id_ready2;
   logic [15:0] id_instr1, id_instr2;
   logic [7:0]  id_pc1, id_pc2;
   logic        halted1, halted2;

   logic [15:0] mem1 [256];
   logic [15:0] mem2 [256];

   cpu_ifetch #(.ADDR_W(8), .RESET_PC(8'h00), .HALT_OPC(4'hF)) dut1 (
      .clk(clk), .reset(reset),
      .imem_en(imem_en1), .imem_addr(imem_addr1), .imem_rdata(imem_rdata1),
      .redirect_valid(redirect_valid1), .redirect_pc(redirect_pc1),
      .id_valid(id_valid1), .id_ready(id_ready1), .id_instr(id_instr1),
      .id_pc(id_pc1), .halted(halted1)
   );

   cpu_ifetch #(.ADDR_W(8), .RESET_PC(8'hFE), .HALT_OPC(4'hF)) dut2 (
      .clk(clk), .reset(reset),
      .imem_en(imem_en2), .imem_addr(imem_addr2), .imem_rdata(imem_rdata2),
      .redirect_valid(redirect_valid2), .redirect_pc(redirect_pc2),
      .id_valid(id_valid2), .id_ready(id_ready2), .id_instr(id_instr2),
      .id_pc(id_pc2), .halted(halted2)
   );

   always @(posedge clk) begin
      if (imem_en1) imem_rdata1 <= mem1[imem_addr1];
      if (imem_en2) imem_rdata2 <= mem2[imem_addr2];
   end

   int checks   = 0;
   int failures = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Leaves the bench at the start of cycle c0, the first cycle with reset low.
   task automatic do_reset();
      reset           = 1'b1;
      redirect_valid1 = 1'b0;
      redirect_pc1    = 8'h00;
      id_ready1       = 1'b1;
      step();
      step();
      reset = 1'b0;
   endtask

   typedef struct {
      logic        ready;
      logic        exp_valid;
      logic [7:0]  exp_pc;
      logic [15:0] exp_instr;
      logic        exp_halted;
      logic        exp_en;
      logic [7:0]  exp_addr;
      logic        exp_valid2;
      logic [7:0]  exp_pc2;
      logic        exp_halted2;
   } vec_t;

   vec_t tbl [10];

   initial begin
      int          nxt;
      logic        stalled;
      logic [7:0]  held_pc;
      logic [15:0] held_instr;
      logic        seen2;

      for (int i = 0; i < 256; i++) begin
         mem1[i] = 16'h0000;
         mem2[i] = 16'h0000;
      end
      mem1[0] = 16'h2224; mem1[1] = 16'h3268; mem1[2] = 16'h42BF;
      mem1[3] = 16'h52C4; mem1[4] = 16'h613C; mem1[5] = 16'hF000;
      mem1[6] = 16'h1111;
      mem2[8'hFE] = 16'h0000; mem2[8'hFF] = 16'h0000; mem2[8'h00] = 16'hF000;

      redirect_valid2 = 1'b0;
      redirect_pc2    = 8'h00;
      id_ready2       = 1'b1;

      //         rdy v  pc     instr     h  en a      v2 pc2    h2
      tbl[0] = '{1, 0, 8'h00, 16'h0000, 0, 1, 8'h00, 0, 8'h00, 0};
      tbl[1] = '{1, 0, 8'h00, 16'h0000, 0, 1, 8'h01, 0, 8'h00, 0};
      tbl[2] = '{1, 1, 8'h00, 16'h2224, 0, 1, 8'h02, 1, 8'hFE, 0};
      tbl[3] = '{1, 1, 8'h01, 16'h3268, 0, 1, 8'h03, 1, 8'hFF, 0};
      tbl[4] = '{1, 1, 8'h02, 16'h42BF, 0, 1, 8'h04, 1, 8'h00, 0};
      tbl[5] = '{1, 1, 8'h03, 16'h52C4, 0, 1, 8'h05, 0, 8'h00, 1};
      tbl[6] = '{1, 1, 8'h04, 16'h613C, 0, 1, 8'h06, 0, 8'h00, 1};
      tbl[7] = '{1, 1, 8'h05, 16'hF000, 0, 0, 8'h00, 0, 8'h00, 1};
      tbl[8] = '{1, 0, 8'h00, 16'h0000, 1, 0, 8'h00, 0, 8'h00, 1};
      tbl[9] = '{1, 0, 8'h00, 16'h0000, 1, 0, 8'h00, 0, 8'h00, 1};

      // Straight-line program, plus the wrapping RESET_PC=FE instance.
      reset = 1'b1;
      #1;
      do_reset();
      for (int c = 0; c < 10; c++) begin
         id_ready1 = tbl[c].ready;
         @(negedge clk);
         check($sformatf("t1 valid c%0d", c), id_valid1, tbl[c].exp_valid);
         if (tbl[c].exp_valid) begin
            check($sformatf("t1 pc c%0d", c), id_pc1, tbl[c].exp_pc);
            check($sformatf("t1 instr c%0d", c), id_instr1, tbl[c].exp_instr);
         end
         check($sformatf("t1 halted c%0d", c), halted1, tbl[c].exp_halted);
         check($sformatf("t1 imem_en c%0d", c), imem_en1, tbl[c].exp_en);
         if (tbl[c].exp_en)
            check($sformatf("t1 imem_addr c%0d", c), imem_addr1, tbl[c].exp_addr);
         check($sformatf("t4 valid c%0d", c), id_valid2, tbl[c].exp_valid2);
         if (tbl[c].exp_valid2)
            check($sformatf("t4 pc c%0d", c), id_pc2, tbl[c].exp_pc2);
         check($sformatf("t4 halted c%0d", c), halted2, tbl[c].exp_halted2);
         step();
      end

      // Stalling decode: ready pattern 1,0,0 repeating.
      do_reset();
      nxt     = 0;
      stalled = 1'b0;
      for (int k = 0; k < 80 && !halted1; k++) begin
         id_ready1 = (k % 3 == 0);
         @(negedge clk);
         if (stalled) begin
            check($sformatf("t2 hold valid k%0d", k), id_valid1, 1'b1);
            check($sformatf("t2 hold pc k%0d", k), id_pc1, held_pc);
            check($sformatf("t2 hold instr k%0d", k), id_instr1, held_instr);
         end
         if (imem_en1)
            check($sformatf("t2 addr bound k%0d", k), (imem_addr1 <= 8'h06), 1'b1);
         if (id_valid1 && id_ready1) begin
            check($sformatf("t2 pop pc k%0d", k), id_pc1, nxt[7:0]);
            check($sformatf("t2 pop instr k%0d", k), id_instr1, mem1[nxt[7:0]]);
            nxt++;
         end
         stalled    = id_valid1 && !id_ready1;
         held_pc    = id_pc1;
         held_instr = id_instr1;
         step();
      end
      check("t2 words popped", nxt, 6);
      check("t2 halted", halted1, 1'b1);

      // Redirect to 4 while the response for address 2 is in flight.
      do_reset();
      seen2 = 1'b0;
      for (int c = 0; c < 7; c++) begin
         redirect_valid1 = (c == 3);
         redirect_pc1    = 8'h04;
         @(negedge clk);
         if (id_valid1 && id_pc1 == 8'h02) seen2 = 1'b1;
         if (c == 3) begin
            check("t3 head at redirect", id_pc1, 8'h01);
            check("t3 no issue at redirect", imem_en1, 1'b0);
         end
         if (c == 4) begin
            check("t3 valid after redirect", id_valid1, 1'b0);
            check("t3 target issue", imem_en1, 1'b1);
            check("t3 target addr", imem_addr1, 8'h04);
         end
         if (c == 5) check("t3 valid c5", id_valid1, 1'b0);
         if (c == 6) begin
            check("t3 valid c6", id_valid1, 1'b1);
            check("t3 pc c6", id_pc1, 8'h04);
            check("t3 instr c6", id_instr1, 16'h613C);
         end
         step();
      end
      redirect_valid1 = 1'b0;
      check("t3 addr2 never presented", seen2, 1'b0);

      // Redirect in the same cycle the HALT word is popped.
      do_reset();
      for (int c = 0; c < 11; c++) begin
         redirect_valid1 = (c == 7);
         redirect_pc1    = 8'h02;
         @(negedge clk);
         if (c == 7) check("t5 halt head", id_instr1, 16'hF000);
         if (c == 8) begin
            check("t5 halted c8", halted1, 1'b0);
            check("t5 valid c8", id_valid1, 1'b0);
            check("t5 issue c8", imem_en1, 1'b1);
            check("t5 addr c8", imem_addr1, 8'h02);
         end
         if (c == 10) begin
            check("t5 valid c10", id_valid1, 1'b1);
            check("t5 pc c10", id_pc1, 8'h02);
            check("t5 instr c10", id_instr1, 16'h42BF);
            check("t5 halted c10", halted1, 1'b0);
         end
         step();
      end
      redirect_valid1 = 1'b0;

      // Reset while in STOP with two words buffered.
      do_reset();
      id_ready1 = 1'b0;
      for (int c = 0; c < 7; c++) begin
         redirect_valid1 = (c == 0);
         redirect_pc1    = 8'h05;
         reset           = (c == 5);
         @(negedge clk);
         if (c == 3) check("t6 no issue in STOP", imem_en1, 1'b0);
         if (c == 4) begin
            check("t6 head valid", id_valid1, 1'b1);
            check("t6 head pc", id_pc1, 8'h05);
            check("t6 head instr", id_instr1, 16'hF000);
         end
         if (c == 5) check("t6 no issue in reset", imem_en1, 1'b0);
         if (c == 6) begin
            check("t6 valid after reset", id_valid1, 1'b0);
            check("t6 halted after reset", halted1, 1'b0);
            check("t6 issue after reset", imem_en1, 1'b1);
            check("t6 addr after reset", imem_addr1, 8'h00);
         end
         step();
      end
      redirect_valid1 = 1'b0;

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
